// File: rtl/rx_fifo_pkg.sv
// Shared types and constants for the UART RX FIFO read-side controller.
package rx_fifo_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    typedef enum logic {
        RTS_GO   = 1'b0,
        RTS_HALT = 1'b1
    } rts_state_t;

    localparam logic [7:0] OVR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/rx_fifo_ctrl_if.sv
// FIFO read port plus consumer valid/ready stream, bundled as one interface.
// The master side is the controller; the slave side is the FIFO/consumer.
interface rx_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  FIFO_RDo;
    logic                  FIFO_FULLi;
    logic                  FIFO_EMPTYi;
    logic [DATA_WIDTH-1:0] FIFO_DATAi;
    logic [DATA_WIDTH-1:0] M_DATAo;
    logic                  M_VALIDo;
    logic                  M_READYi;

    modport master (
        output FIFO_RDo,
        input  FIFO_FULLi,
        input  FIFO_EMPTYi,
        input  FIFO_DATAi,
        output M_DATAo,
        output M_VALIDo,
        input  M_READYi
    );

    modport slave (
        input  FIFO_RDo,
        output FIFO_FULLi,
        output FIFO_EMPTYi,
        output FIFO_DATAi,
        input  M_DATAo,
        input  M_VALIDo,
        output M_READYi
    );

endinterface

// File: rtl/rx_skid_buf.sv
// Two-entry output buffer that absorbs the FIFO's registered read latency.
// Bytes captured from the FIFO leave in arrival order on a valid/ready port;
// the head entry is always what the consumer sees.
module rx_skid_buf
    import rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLKip,
    input  logic                  RSTi,
    input  logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [1:0]            buf_cnt
);

    buf_state_t            state_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  valid_q;
    logic                  fire;

    assign fire      = valid_q & out_ready;
    assign out_data  = head_q;
    assign out_valid = valid_q;

    // Buffer state machine: head/tail storage with a registered valid flag.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (cap_en) begin
                        head_q  <= cap_data;
                        state_q <= BUF_ONE;
                        valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (cap_en && !fire) begin
                        tail_q  <= cap_data;
                        state_q <= BUF_TWO;
                    end else if (cap_en && fire) begin
                        head_q  <= cap_data;
                    end else if (fire) begin
                        state_q <= BUF_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (fire) begin
                        head_q <= tail_q;
                        if (cap_en) begin
                            tail_q <= cap_data;
                        end else begin
                            state_q <= BUF_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= BUF_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy reported to the pop credit logic.
    always_comb begin
        buf_cnt = 2'd0;
        case (state_q)
            BUF_ONE: buf_cnt = 2'd1;
            BUF_TWO: buf_cnt = 2'd2;
            default: buf_cnt = 2'd0;
        endcase
    end

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Read-side sequencer for the UART RX FIFO: issues pops on a 2-entry credit,
// feeds the output buffer, tracks a shadow occupancy level, drives hysteretic
// RTS toward the remote transmitter and records dropped bytes.
module rx_fifo_ctrl
    import rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1,
    parameter int RTS_OFF_LVL = 12,
    parameter int RTS_ON_LVL  = 4
) (
    input  logic             CLKip,
    input  logic             RSTi,
    input  logic             WR_STBi,
    rx_fifo_ctrl_if.master   bus,
    output logic             RTS_No,
    output logic [LVL_W-1:0] LEVELo,
    output logic             OVERRUNo,
    output logic [7:0]       OVR_CNTo,
    input  logic             OVR_CLRi
);

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] OFF_LVL = LVL_W'(RTS_OFF_LVL);
    localparam logic [LVL_W-1:0] ON_LVL  = LVL_W'(RTS_ON_LVL);

    logic                  wr_acc;
    logic                  drop;
    logic                  rd;
    logic                  inflight_q;
    logic                  out_fire;
    logic [1:0]            buf_cnt;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_next;
    rts_state_t            rts_state_q;
    logic                  rts_n_q;
    logic                  ovr_q;
    logic [7:0]            ovr_cnt_q;

    assign wr_acc   = WR_STBi & ~bus.FIFO_FULLi;
    assign drop     = WR_STBi & bus.FIFO_FULLi;
    assign out_fire = m_valid & bus.M_READYi;

    // Bytes already held plus the one arriving, minus the one leaving, must
    // leave room in the buffer before another pop is allowed.
    always_comb begin
        occ = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, out_fire};
        rd  = ~bus.FIFO_EMPTYi & (occ < 3'd2);
    end

    assign bus.FIFO_RDo = rd;
    assign bus.M_DATAo  = m_data;
    assign bus.M_VALIDo = m_valid;
    assign RTS_No       = rts_n_q;
    assign LEVELo       = level_q;
    assign OVERRUNo     = ovr_q;
    assign OVR_CNTo     = ovr_cnt_q;

    rx_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .CLKip     (CLKip),
        .RSTi      (RSTi),
        .cap_en    (inflight_q),
        .cap_data  (bus.FIFO_DATAi),
        .out_ready (bus.M_READYi),
        .out_data  (m_data),
        .out_valid (m_valid),
        .buf_cnt   (buf_cnt)
    );

    // Remember last cycle's pop; its data is on FIFO_DATAi this cycle.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd;
        end
    end

    // Next shadow level, clamped so it can never wrap.
    always_comb begin
        level_next = level_q;
        if (wr_acc && !rd && level_q != LVL_MAX) begin
            level_next = level_q + LVL_W'(1);
        end else if (!wr_acc && rd && level_q != '0) begin
            level_next = level_q - LVL_W'(1);
        end
    end

    // Shadow FIFO occupancy register.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            level_q <= '0;
        end else begin
            level_q <= level_next;
        end
    end

    // RTS hysteresis: halt at the high mark, resume only at the low mark.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            rts_state_q <= RTS_GO;
            rts_n_q     <= 1'b0;
        end else begin
            case (rts_state_q)
                RTS_GO: begin
                    if (level_next >= OFF_LVL) begin
                        rts_state_q <= RTS_HALT;
                        rts_n_q     <= 1'b1;
                    end
                end
                RTS_HALT: begin
                    if (level_next <= ON_LVL) begin
                        rts_state_q <= RTS_GO;
                        rts_n_q     <= 1'b0;
                    end
                end
                default: begin
                    rts_state_q <= RTS_GO;
                    rts_n_q     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag and saturating drop counter; a drop beats a clear.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= 8'd0;
        end else if (OVR_CLRi && drop) begin
            ovr_q     <= 1'b1;
            ovr_cnt_q <= 8'd1;
        end else if (OVR_CLRi) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= 8'd0;
        end else if (drop) begin
            ovr_q <= 1'b1;
            if (ovr_cnt_q != OVR_CNT_MAX) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed testbench for rx_fifo_ctrl with a behavioural 16-entry FIFO
// (registered read data) in front of it and a monitor on the output stream.
module tb_rx_fifo_ctrl;

    logic       CLKip;
    logic       RSTi;
    logic       WR_STBi;
    logic [7:0] wr_data;
    logic       OVR_CLRi;
    logic       RTS_No;
    logic [4:0] LEVELo;
    logic       OVERRUNo;
    logic [7:0] OVR_CNTo;

    int total;
    int bad;
    int cyc;
    int popCnt;
    int popEmpty;
    logic [7:0] rxq[$];
    int rxcyc[$];

    logic [7:0] fmem [16];
    logic [3:0] fwp;
    logic [3:0] frp;
    logic [4:0] fcnt;
    logic [7:0] fdout;
    logic       fwe_ok;
    logic       frd_ok;

    rx_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

    rx_fifo_ctrl dut (
        .CLKip    (CLKip),
        .RSTi     (RSTi),
        .WR_STBi  (WR_STBi),
        .bus      (bus),
        .RTS_No   (RTS_No),
        .LEVELo   (LEVELo),
        .OVERRUNo (OVERRUNo),
        .OVR_CNTo (OVR_CNTo),
        .OVR_CLRi (OVR_CLRi)
    );

    initial CLKip = 1'b0;
    always #5 CLKip = ~CLKip;

    assign fwe_ok          = WR_STBi && (fcnt != 5'd16);
    assign frd_ok          = bus.FIFO_RDo && (fcnt != 5'd0);
    assign bus.FIFO_FULLi  = (fcnt == 5'd16);
    assign bus.FIFO_EMPTYi = (fcnt == 5'd0);
    assign bus.FIFO_DATAi  = fdout;

    // Behavioural RX FIFO sharing the controller's reset.
    always @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            fwp   <= 4'd0;
            frp   <= 4'd0;
            fcnt  <= 5'd0;
            fdout <= 8'd0;
        end else begin
            if (fwe_ok) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 4'd1;
            end
            if (frd_ok) begin
                fdout <= fmem[frp];
                frp   <= frp + 4'd1;
            end
            fcnt <= fcnt + {4'b0, fwe_ok} - {4'b0, frd_ok};
        end
    end

    // Stream and pop monitor, sampled mid-cycle.
    always @(negedge CLKip) begin
        cyc = cyc + 1;
        if (!RSTi) begin
            if (bus.M_VALIDo && bus.M_READYi) begin
                rxq.push_back(bus.M_DATAo);
                rxcyc.push_back(cyc);
            end
            if (bus.FIFO_RDo) popCnt = popCnt + 1;
            if (bus.FIFO_RDo && bus.FIFO_EMPTYi) popEmpty = popEmpty + 1;
        end
    end

    task automatic tick();
        @(posedge CLKip);
        #2;
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rdy);
        WR_STBi      = wr;
        wr_data      = d;
        bus.M_READYi = rdy;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkQueue(input string tag, input int n, input logic [7:0] first, input logic [7:0] stride);
        logic [7:0] e;
        logic [31:0] g;
        checkOutput({tag, "_count"}, rxq.size(), n);
        e = first;
        for (int i = 0; i < n; i++) begin
            g = (i < rxq.size()) ? {24'd0, rxq[i]} : 32'h1FF;
            checkOutput($sformatf("%s_%0d", tag, i), g, {24'd0, e});
            e = e + stride;
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; popCnt = 0; popEmpty = 0;
        RSTi = 1'b1; WR_STBi = 1'b0; wr_data = 8'd0; OVR_CLRi = 1'b0;
        bus.M_READYi = 1'b0;
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("rst_rd",    bus.FIFO_RDo, 0);
        checkOutput("rst_valid", bus.M_VALIDo, 0);
        checkOutput("rst_data",  bus.M_DATAo, 0);
        checkOutput("rst_level", LEVELo, 0);
        checkOutput("rst_rts",   RTS_No, 0);
        checkOutput("rst_ovr",   OVERRUNo, 0);
        checkOutput("rst_ocnt",  OVR_CNTo, 0);
        RSTi = 1'b0;
        tick();

        $display("[TB] single byte");
        popCnt = 0;
        applyStimulus(1'b1, 8'hA5, 1'b1);
        WR_STBi = 1'b0;
        checkOutput("sb_rd_t",     bus.FIFO_RDo, 1);
        checkOutput("sb_level_t",  LEVELo, 1);
        checkOutput("sb_valid_t",  bus.M_VALIDo, 0);
        tick();
        checkOutput("sb_rd_t1",    bus.FIFO_RDo, 0);
        checkOutput("sb_level_t1", LEVELo, 0);
        checkOutput("sb_valid_t1", bus.M_VALIDo, 0);
        tick();
        checkOutput("sb_valid_t2", bus.M_VALIDo, 1);
        checkOutput("sb_data_t2",  bus.M_DATAo, 8'hA5);
        tick();
        checkOutput("sb_valid_t3", bus.M_VALIDo, 0);
        checkOutput("sb_pops",     popCnt, 1);

        $display("[TB] burst of 16");
        rxq.delete(); rxcyc.delete(); popEmpty = 0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b1);
        repeat (5) applyStimulus(1'b0, 8'd0, 1'b1);
        checkQueue("burst", 16, 8'h00, 8'h01);
        checkOutput("burst_span", (rxcyc.size() == 16) ? rxcyc[15] - rxcyc[0] : -1, 15);
        checkOutput("burst_pop_empty", popEmpty, 0);
        checkOutput("burst_level", LEVELo, 0);

        $display("[TB] backpressure");
        rxq.delete(); popCnt = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + 3 * i), 1'b0);
        repeat (12) applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("bp_pops",  popCnt, 2);
        checkOutput("bp_level", LEVELo, 6);
        checkOutput("bp_valid", bus.M_VALIDo, 1);
        checkOutput("bp_head",  bus.M_DATAo, 8'h10);
        checkOutput("bp_none",  rxq.size(), 0);
        repeat (12) applyStimulus(1'b0, 8'd0, 1'b1);
        checkQueue("bp", 8, 8'h10, 8'h03);
        checkOutput("bp_level_end", LEVELo, 0);

        $display("[TB] RTS hysteresis");
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
        checkOutput("rts_lvl11",  LEVELo, 11);
        checkOutput("rts_go11",   RTS_No, 0);
        applyStimulus(1'b1, 8'h4D, 1'b0);
        checkOutput("rts_lvl12",  LEVELo, 12);
        checkOutput("rts_halt12", RTS_No, 1);
        repeat (7) applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("rts_lvl5",   LEVELo, 5);
        checkOutput("rts_halt5",  RTS_No, 1);
        repeat (2) applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("rts_hold5",  LEVELo, 5);
        checkOutput("rts_hold5r", RTS_No, 1);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("rts_lvl4",   LEVELo, 4);
        checkOutput("rts_go4",    RTS_No, 0);
        repeat (12) applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("rts_drained", LEVELo, 0);
        checkOutput("rts_empty",   bus.M_VALIDo, 0);

        $display("[TB] overrun");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
        WR_STBi = 1'b0;
        checkOutput("ovr_flag",  OVERRUNo, 1);
        checkOutput("ovr_cnt",   OVR_CNTo, 2);
        checkOutput("ovr_level", LEVELo, 16);
        checkOutput("ovr_rts",   RTS_No, 1);
        OVR_CLRi = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("ovr_clr_flag", OVERRUNo, 0);
        checkOutput("ovr_clr_cnt",  OVR_CNTo, 0);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        OVR_CLRi = 1'b0;
        checkOutput("ovr_setwins_flag", OVERRUNo, 1);
        checkOutput("ovr_setwins_cnt",  OVR_CNTo, 1);
        repeat (300) applyStimulus(1'b1, 8'hEE, 1'b0);
        WR_STBi = 1'b0;
        checkOutput("ovr_sat_cnt",   OVR_CNTo, 8'hFF);
        checkOutput("ovr_sat_level", LEVELo, 16);
        checkOutput("pop_while_empty", popEmpty, 0);

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b0, 8'd0, 1'b1);
        RSTi = 1'b1;
        #1;
        checkOutput("mid_rst_rd",    bus.FIFO_RDo, 0);
        checkOutput("mid_rst_valid", bus.M_VALIDo, 0);
        checkOutput("mid_rst_data",  bus.M_DATAo, 0);
        checkOutput("mid_rst_level", LEVELo, 0);
        checkOutput("mid_rst_rts",   RTS_No, 0);
        checkOutput("mid_rst_ovr",   OVERRUNo, 0);
        checkOutput("mid_rst_ocnt",  OVR_CNTo, 0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        RSTi = 1'b0;
        tick();
        rxq.delete();
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("post_valid_t1", bus.M_VALIDo, 0);
        tick();
        checkOutput("post_valid_t2", bus.M_VALIDo, 1);
        checkOutput("post_data_t2",  bus.M_DATAo, 8'h3C);
        repeat (3) applyStimulus(1'b0, 8'd0, 1'b1);
        checkQueue("post", 1, 8'h3C, 8'h00);
        checkOutput("post_valid_end", bus.M_VALIDo, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_fifo_ctrl.md
# rx_fifo_ctrl

Read-side sequencer and flow-control manager for the UART receiver FIFO. It sits between the 16-entry synchronous RX FIFO and the system byte consumer. It issues FIFO pops, absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer, and presents bytes on a valid/ready stream. It also keeps a shadow occupancy count, drives hysteretic RTS flow control toward the remote transmitter, and records overruns.

## Interface
- DATA_WIDTH, 8: byte width; must match the FIFO.
- FIFO_DEPTH, 16: FIFO depth; power of 2.
- LVL_W, $clog2(FIFO_DEPTH)+1: occupancy counter width.
- RTS_OFF_LVL, 12: occupancy at or above which the remote transmitter is halted.
- RTS_ON_LVL, 4: occupancy at or below which the remote transmitter is resumed; must be < RTS_OFF_LVL.
- CLKip  in  1  clock; all logic on the rising edge.
- RSTi  in  1  reset, asynchronous, active-high.
- WR_STBi  in  1  RX byte strobe; the same signal drives the FIFO WEi.
- FIFO_FULLi  in  1  FIFO FULLo.
- FIFO_EMPTYi  in  1  FIFO EMPTYo.
- FIFO_RDo  out  1  pop request to FIFO RDi.
- FIFO_DATAi  in  DATA_WIDTH  FIFO DATAo; valid one cycle after a pop.
- M_DATAo  out  DATA_WIDTH  output byte.
- M_VALIDo  out  1  output byte valid.
- M_READYi  in  1  consumer ready.
- RTS_No  out  1  active-low request-to-send; 0 = remote may transmit.
- LEVELo  out  LVL_W  shadow FIFO occupancy.
- OVERRUNo  out  1  sticky overrun flag.
- OVR_CNTo  out  8  saturating count of dropped bytes.
- OVR_CLRi  in  1  synchronous clear of OVERRUNo and OVR_CNTo.

## Operation
- Accepted write: wr_acc = WR_STBi & ~FIFO_FULLi.
- Pop: FIFO_RDo is combinational. It is asserted when ~FIFO_EMPTYi & (buf_cnt + inflight − out_fire) < 2, where:
  - out_fire = M_VALIDo & M_READYi;
  - inflight = registered copy of the previous cycle's FIFO_RDo.
- FIFO_RDo is never asserted while FIFO_EMPTYi = 1.
- Capture: when inflight = 1, FIFO_DATAi is written into the output buffer in that cycle.
- Output buffer states:
  - BUF_EMPTY → BUF_ONE on capture.
  - BUF_ONE → BUF_TWO on capture without out_fire.
  - BUF_ONE → BUF_EMPTY on out_fire without capture.
  - BUF_TWO → BUF_ONE on out_fire. Capture cannot occur in BUF_TWO because the credit rule forbids it.
  - Capture and out_fire together in BUF_ONE: stay in BUF_ONE, new head is the captured byte.
- Output order: strict FIFO order. M_DATAo is always the head entry. M_VALIDo = (state != BUF_EMPTY).
- M_DATAo and M_VALIDo hold stable while M_VALIDo & ~M_READYi.
- Shadow level: LEVELo_next = LEVELo + wr_acc − FIFO_RDo, so simultaneous accept and pop leaves it unchanged. Range 0..FIFO_DEPTH; never wraps.
- RTS state machine:
  - RTS_GO (RTS_No = 0) → RTS_HALT when LEVELo_next ≥ RTS_OFF_LVL.
  - RTS_HALT (RTS_No = 1) → RTS_GO when LEVELo_next ≤ RTS_ON_LVL.
- Overrun: WR_STBi & FIFO_FULLi sets OVERRUNo and increments OVR_CNTo, which saturates at 255.
  - OVR_CLRi clears both.
  - OVR_CLRi and a drop in the same cycle: OVERRUNo = 1, OVR_CNTo = 1 (set wins).

## Timing
- Reset values:
  - FIFO_RDo 0, inflight 0, buffer BUF_EMPTY.
  - M_VALIDo 0, M_DATAo 0.
  - LEVELo 0.
  - RTS_No 0 (RTS_GO).
  - OVERRUNo 0, OVR_CNTo 0.
- Latency: a byte written at edge t (FIFO non-empty from t) has FIFO_RDo asserted in cycle t. It is captured at t+1 and shows M_VALIDo = 1 after edge t+2, i.e. 2 cycles from FIFO non-empty to valid output.
- Throughput: 1 byte/cycle sustained with M_READYi held at 1.
- RTS_No updates one edge after the level crosses a threshold.
- Reset asserted mid-transfer: all state clears immediately, including any in-flight byte and buffered bytes. The FIFO shares RSTi, so the shadow level stays consistent.

## Structure
- Package rx_fifo_pkg holds:
  - buf_state_t {BUF_EMPTY, BUF_ONE, BUF_TWO};
  - rts_state_t {RTS_GO, RTS_HALT};
  - OVR_CNT_MAX = 8'hFF.
- Sub-module rx_skid_buf: the 2-entry output buffer with its state machine, capture port and valid/ready port. The top level holds the credit/pop logic, level counter, RTS state machine and overrun logic.

## Test plan
- Single byte: write 0xA5 with M_READYi = 1 → FIFO_RDo pulses once; M_VALIDo rises 2 cycles later with M_DATAo = 0xA5; LEVELo goes 1 → 0.
- Burst of 16 bytes 0x00..0x0F with M_READYi = 1 → output is 0x00..0x0F in order, one per cycle after the 2-cycle fill; no pop while empty.
- Backpressure: M_READYi = 0 for 20 cycles with 8 bytes written → exactly 2 pops issued; LEVELo = 6; M_DATAo held at the first byte; after release, all 8 bytes arrive in order.
- RTS hysteresis: fill to 12 → RTS_No = 1; drain to 5 → still 1; drain to 4 → RTS_No = 0.
- Overrun: M_READYi = 0, write 20 bytes → OVERRUNo = 1, OVR_CNTo = 2, LEVELo = 16; OVR_CLRi pulse → both 0.
- Reset with 2 bytes buffered and a pop in flight → all outputs at reset values next cycle; after release, new byte 0x3C is delivered correctly.
